// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if
//   E-stage <-> multiply/divide unit bundle.
//   master : E stage / hazard side (drives op request, reads status and HI/LO)
//   slave  : md_unit_ctrl
//   start    : E-stage instruction is an MDU op
//   op       : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   rs_val   : forwarded rs operand
//   rt_val   : forwarded rt operand
//   hilo_rd  : E-stage instruction is MFHI/MFLO
//   IRQ      : interrupt flush of the E stage this cycle
//   busy     : operation in progress
//   stall_req: hold F/D/E, bubble E->M
//   hi, lo   : architectural HI/LO registers
interface md_unit_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hilo_rd;
  logic        IRQ;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hilo_rd, IRQ,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hilo_rd, IRQ,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl
//   Multi-cycle multiply/divide sequencer beside the E-stage ALU. Owns HI/LO.
//   The full 64-bit result is computed at the accept edge and held in res_q;
//   the FSM only models latency, then commits res_q to {hi,lo}.
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-high; clears FSM, counter, result, HI/LO
//     mdu   : md_unit_ctrl_if.slave (request, status, HI/LO)
//   Parameters:
//     MULT_CYCLES : busy cycles for MULT/MULTU (2..15)
//     DIV_CYCLES  : busy cycles for DIV/DIVU   (2..15)
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  md_unit_ctrl_if.slave  mdu
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic accept;
  assign accept = mdu.start & ~mdu.IRQ & (state_q == IDLE);

  // op[0]==0 selects the signed flavour for both MULT/MULTU and DIV/DIVU
  logic sgn;
  assign sgn = ~mdu.op[0];

  // One multiplier: sign- or zero-extend to 64 bits, keep the low 64 bits
  logic [63:0] a_ext, b_ext, mul_res;
  assign a_ext   = {{32{sgn & mdu.rs_val[31]}}, mdu.rs_val};
  assign b_ext   = {{32{sgn & mdu.rt_val[31]}}, mdu.rt_val};
  assign mul_res = a_ext * b_ext;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out naturally
  // (magnitude 0x80000000 negates to itself, remainder 0).
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, uq, ur, q, r;
  logic [63:0] div_res;
  assign a_neg   = sgn & mdu.rs_val[31];
  assign b_neg   = sgn & mdu.rt_val[31];
  assign a_mag   = a_neg ? -mdu.rs_val : mdu.rs_val;
  assign b_mag   = b_neg ? -mdu.rt_val : mdu.rt_val;
  assign uq      = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign ur      = (b_mag == '0) ? '0 : a_mag % b_mag;
  assign q       = (a_neg ^ b_neg) ? -uq : uq;
  assign r       = a_neg ? -ur : ur;
  assign div_res = (mdu.rt_val == '0) ? {mdu.rs_val, 32'hFFFF_FFFF} : {r, q};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (mdu.op)
            OP_MULT, OP_MULTU: begin
              res_d   = mul_res;
              cnt_d   = MULT_CNT;
              state_d = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              res_d   = div_res;
              cnt_d   = DIV_CNT;
              state_d = BUSY;
            end
            OP_MTHI: hi_d = mdu.rs_val;
            OP_MTLO: lo_d = mdu.rs_val;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          {hi_d, lo_d} = res_q;
          state_d      = IDLE;
        end
      end
    endcase
  end

  // Outputs: busy is a decode of the state register; stall_req only while busy
  always_comb begin
    mdu.busy      = (state_q == BUSY);
    mdu.stall_req = (mdu.start | mdu.hilo_rd) & (state_q == BUSY);
    mdu.hi        = hi_q;
    mdu.lo        = lo_q;
  end

endmodule
